// File: rtl/wbcxbar_rr_pkg.sv
// Shared definitions for the round-robin Wishbone crossbar.
//  - Default bus widths used by the crossbar and its arbiter.
//  - idx_width(): index width for an N-entry set. It is never below 1 bit,
//    so single-port configurations still elaborate.
package wbcxbar_rr_pkg;

  localparam int WB_AW = 30;  // word address width
  localparam int WB_DW = 32;  // data width

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbc_rr_arbiter.sv
// Round-robin grant holder for one crossbar slave port.
//  clk        in   1    bus clock
//  rst_n      in   1    asynchronous, active-low reset
//  req        in   NM   masters currently strobing this slave
//  cyc        in   NM   master CYC lines, used to hold the grant
//  gnt        out  NM   one-hot grant (all zero when idle)
//  gnt_valid  out  1    a master owns this slave
//  gnt_idx    out  IW   index of the owning master
// A grant is taken on the edge after a request. It stays until the owner
// drops CYC. Re-arbitration waits one further edge, so two owners never
// overlap.
module wbc_rr_arbiter
  import wbcxbar_rr_pkg::*;
#(
  parameter  int NM = 2,
  localparam int IW = idx_width(NM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NM-1:0] req,
  input  logic [NM-1:0] cyc,
  output logic [NM-1:0] gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;        // last grantee
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  int            cand;

  // Scan from the master after the last grantee and wrap past NM-1 to 0.
  // Take the first master that is requesting.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NM; k++) begin
      // NOTE: blocking assignments here; each loop pass must see the previous pass's result.
      cand = (int'(ptr) + k) % NM;
      if (!pick_found && req[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state, so every register updates from pre-edge values.
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= IW'(NM - 1);  // master 0 wins the first contest
    end else if (gnt_valid) begin
      if (!cyc[gnt_idx]) gnt_valid <= 1'b0;
    end else if (pick_found) begin
      gnt_valid <= 1'b1;
      gnt_idx   <= pick_idx;
      ptr       <= pick_idx;
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/wbcxbar_rr.sv
// Classic (non-pipelined) Wishbone crossbar. It connects NM masters to NS
// slaves.
//  - The slave is decoded from the top MUXWIDTH address bits. Each slave is
//    arbitrated round-robin with a 1-cycle grant latency.
//  - Forward and return paths are combinational from the owner.
//  - A bus error is returned for:
//      * an unmapped address (registered 1-cycle pulse),
//      * an owner strobing a different slave (registered 1-cycle pulse),
//      * an unacked forwarded strobe lasting TIMEOUT cycles.
// Ports: i_clk/i_reset_n (async active-low).
//  Master side: i_mcyc, i_mstb, i_mwe, i_maddr, i_mdata, i_msel in;
//               o_mack, o_merr, o_mdata out.
//  Slave side:  o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel out;
//               i_sack, i_serr, i_sdata in.
//  Multi-port buses are packed, with slot i at [i*W +: W].
module wbcxbar_rr
  import wbcxbar_rr_pkg::*;
#(
  parameter int NM        = 2,
  parameter int NS        = 3,
  parameter int AW        = WB_AW,
  parameter int DW        = WB_DW,
  parameter int MUXWIDTH  = 4,
  parameter     SLAVE_MUX = 12'h012,
  parameter int TIMEOUT   = 1024
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NM-1:0]      i_mcyc,
  input  logic [NM-1:0]      i_mstb,
  input  logic [NM-1:0]      i_mwe,
  input  logic [NM*AW-1:0]   i_maddr,
  input  logic [NM*DW-1:0]   i_mdata,
  input  logic [NM*DW/8-1:0] i_msel,
  output logic [NM-1:0]      o_mack,
  output logic [NM-1:0]      o_merr,
  output logic [NM*DW-1:0]   o_mdata,
  output logic [NS-1:0]      o_scyc,
  output logic [NS-1:0]      o_sstb,
  output logic [NS-1:0]      o_swe,
  output logic [NS*AW-1:0]   o_saddr,
  output logic [NS*DW-1:0]   o_sdata,
  output logic [NS*DW/8-1:0] o_ssel,
  input  logic [NS-1:0]      i_sack,
  input  logic [NS-1:0]      i_serr,
  input  logic [NS*DW-1:0]   i_sdata
);

  localparam int SW  = DW / 8;
  localparam int MIW = idx_width(NM);
  localparam int SIW = idx_width(NS);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // ---------------- elaboration-time parameter checks ----------------
  function automatic bit mux_has_dup();
    for (int i = 0; i < NS; i++)
      for (int j = i + 1; j < NS; j++)
        if (SLAVE_MUX[i*MUXWIDTH +: MUXWIDTH] == SLAVE_MUX[j*MUXWIDTH +: MUXWIDTH])
          return 1'b1;
    return 1'b0;
  endfunction

  if ($bits(SLAVE_MUX) != NS * MUXWIDTH) begin : g_bad_mux_width
    $fatal(1, "wbcxbar_rr: SLAVE_MUX width must equal NS*MUXWIDTH");
  end
  if (MUXWIDTH > AW) begin : g_bad_muxwidth
    $fatal(1, "wbcxbar_rr: MUXWIDTH exceeds AW");
  end
  if ($bits(SLAVE_MUX) == NS * MUXWIDTH && mux_has_dup()) begin : g_dup_mux
    $fatal(1, "wbcxbar_rr: duplicate SLAVE_MUX decode value");
  end

  // ---------------- request decode ----------------
  logic [NM-1:0] req;
  logic [NM-1:0] mapped;
  logic [NS-1:0] hit [NM];  // one-hot target slave per master, lowest match wins

  always_comb begin
    req    = '0;
    mapped = '0;
    for (int m = 0; m < NM; m++) begin
      req[m] = i_mcyc[m] & i_mstb[m];
      hit[m] = '0;
      for (int s = 0; s < NS; s++)
        if (hit[m] == '0 &&
            i_maddr[m*AW+AW-1 -: MUXWIDTH] == SLAVE_MUX[s*MUXWIDTH +: MUXWIDTH])
          hit[m][s] = 1'b1;
      mapped[m] = |hit[m];
    end
  end

  // ---------------- per-slave arbitration ----------------
  logic [NM-1:0]  sreq [NS];
  logic [NM-1:0]  sgnt [NS];
  logic [NS-1:0]  gv;
  logic [MIW-1:0] gidx [NS];
  logic [NM-1:0]  owns;
  logic [SIW-1:0] own  [NM];

  // A master already holding a slave must not compete for a second one.
  // Strobing a different slave while owning one is an error, not a request.
  always_comb begin
    owns = '0;
    for (int m = 0; m < NM; m++) own[m] = '0;
    for (int s = 0; s < NS; s++)
      for (int m = 0; m < NM; m++)
        if (sgnt[s][m]) begin
          owns[m] = 1'b1;
          own[m]  = SIW'(s);
        end
    for (int s = 0; s < NS; s++)
      for (int m = 0; m < NM; m++)
        sreq[s][m] = req[m] & hit[m][s] & ~owns[m];
  end

  for (genvar s = 0; s < NS; s++) begin : g_arb
    wbc_rr_arbiter #(.NM(NM)) u_arb (
      .clk       (i_clk),
      .rst_n     (i_reset_n),
      .req       (sreq[s]),
      .cyc       (i_mcyc),
      .gnt       (sgnt[s]),
      .gnt_valid (gv[s]),
      .gnt_idx   (gidx[s])
    );
  end

  // ---------------- forward path: owner -> slave ----------------
  always_comb begin
    o_scyc  = '0;
    o_sstb  = '0;
    o_swe   = '0;
    o_saddr = '0;
    o_sdata = '0;
    o_ssel  = '0;
    for (int s = 0; s < NS; s++)
      if (gv[s]) begin
        o_scyc[s]            = i_mcyc[gidx[s]];
        // Only forward a strobe that still decodes to this slave.
        o_sstb[s]            = i_mcyc[gidx[s]] & i_mstb[gidx[s]] & hit[gidx[s]][s];
        o_swe[s]             = i_mwe[gidx[s]];
        o_saddr[s*AW +: AW]  = i_maddr[int'(gidx[s])*AW +: AW];
        o_sdata[s*DW +: DW]  = i_mdata[int'(gidx[s])*DW +: DW];
        o_ssel[s*SW +: SW]   = i_msel[int'(gidx[s])*SW +: SW];
      end
  end

  // ---------------- return path: owned slave -> master ----------------
  logic [NM-1:0] serr_m;    // slave error routed to its owner
  logic [NM-1:0] fwd;       // owner's strobe is reaching its slave
  logic [NM-1:0] bad;       // unmapped, or strobing a slave other than the owned one
  logic [NM-1:0] err_q;
  logic [NM-1:0] to_pulse;

  always_comb begin
    o_mack  = '0;
    o_mdata = '0;
    serr_m  = '0;
    fwd     = '0;
    bad     = '0;
    for (int m = 0; m < NM; m++) begin
      if (owns[m]) begin
        o_mack[m]            = i_sack[own[m]];
        serr_m[m]            = i_serr[own[m]];
        o_mdata[m*DW +: DW]  = i_sdata[int'(own[m])*DW +: DW];
        fwd[m]               = req[m] & hit[m][own[m]];
        bad[m]               = req[m] & ~hit[m][own[m]];
      end else begin
        bad[m] = req[m] & ~mapped[m];
      end
    end
  end

  // The master sees the error one cycle late and drops STB a cycle after that.
  // Masking with err_q keeps the pulse to a single cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) err_q <= '0;
    else            err_q <= bad & ~err_q;
  end

  // ---------------- ack timeout ----------------
  if (TIMEOUT > 0) begin : g_timeout
    logic [TW-1:0] cnt [NM];
    logic [NM-1:0] fired;  // pulse already issued for this stalled strobe

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        for (int m = 0; m < NM; m++) cnt[m] <= '0;
        fired <= '0;
      end else begin
        for (int m = 0; m < NM; m++) begin
          if (!fwd[m] || o_mack[m] || serr_m[m]) begin
            cnt[m]   <= '0;
            fired[m] <= 1'b0;
          end else if (cnt[m] != TW'(TIMEOUT)) begin
            cnt[m] <= cnt[m] + 1'b1;
          end else begin
            fired[m] <= 1'b1;
          end
        end
      end
    end

    always_comb begin
      to_pulse = '0;
      for (int m = 0; m < NM; m++)
        to_pulse[m] = (cnt[m] == TW'(TIMEOUT)) & ~fired[m];
    end
  end else begin : g_no_timeout
    assign to_pulse = '0;
  end

  assign o_merr = serr_m | err_q | to_pulse;

endmodule

// File: tb/tb_wbcxbar_rr.sv
// Directed self-checking bench for wbcxbar_rr (NM=2, NS=3, TIMEOUT=8).
// Expected data words are queued when a transaction is launched. They are
// popped when the DUT presents the data.
module tb_wbcxbar_rr;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // Word addresses: the top 4 bits select slave0=2, slave1=1, slave2=0; 3 is unmapped.
  localparam logic [AW-1:0] A_S0 = 30'h0800_0000;
  localparam logic [AW-1:0] A_S1 = 30'h0400_0001;  // byte address 0x1000_0004
  localparam logic [AW-1:0] A_S2 = 30'h0000_0010;
  localparam logic [AW-1:0] A_UN = 30'h0C00_0000;  // byte address 0x3000_0000

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     mcyc, mstb, mwe;
  logic [NM*AW-1:0]  maddr;
  logic [NM*DW-1:0]  mdata;
  logic [NM*SW-1:0]  msel;
  logic [NM-1:0]     o_mack, o_merr;
  logic [NM*DW-1:0]  o_mdata;
  logic [NS-1:0]     o_scyc, o_sstb, o_swe;
  logic [NS*AW-1:0]  o_saddr;
  logic [NS*DW-1:0]  o_sdata;
  logic [NS*SW-1:0]  o_ssel;
  logic [NS-1:0]     sack, serr;
  logic [NS*DW-1:0]  sdata;

  always #5 clk = ~clk;

  wbcxbar_rr #(.TIMEOUT(TO)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_mcyc    (mcyc),
    .i_mstb    (mstb),
    .i_mwe     (mwe),
    .i_maddr   (maddr),
    .i_mdata   (mdata),
    .i_msel    (msel),
    .o_mack    (o_mack),
    .o_merr    (o_merr),
    .o_mdata   (o_mdata),
    .o_scyc    (o_scyc),
    .o_sstb    (o_sstb),
    .o_swe     (o_swe),
    .o_saddr   (o_saddr),
    .o_sdata   (o_sdata),
    .o_ssel    (o_ssel),
    .i_sack    (sack),
    .i_serr    (serr),
    .i_sdata   (sdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [DW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [DW-1:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_underflow: observed %0h expected a queued entry", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, {32'h0, obs}, {32'h0, e.val});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mcyc[m]             = cyc;
    mstb[m]             = stb;
    mwe[m]              = we;
    maddr[m*AW +: AW]   = addr;
    mdata[m*DW +: DW]   = data;
    msel[m*SW +: SW]    = '1;
  endtask

  task automatic idle_m(input int m);
    drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic set_s(input int s, input logic ack, input logic [DW-1:0] data);
    sack[s]            = ack;
    sdata[s*DW +: DW]  = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    mcyc = '0; mstb = '0; mwe = '0; maddr = '0; mdata = '0; msel = '0;
    sack = '0; serr = '0; sdata = '0;
    #23 rst_n = 1'b1;
    tick();
    check("rst_scyc", o_scyc, 0);
    check("rst_mack", o_mack, 0);
    check("rst_merr", o_merr, 0);

    // ---- single master read of slave 1 ----
    drive_m(0, 1, 1, 0, A_S1, '0);
    sb_push("t1_rdata_m0", 32'hA5A5_0001);
    #1;
    check("t1_no_early_scyc", o_scyc, 3'b000);
    tick();
    check("t1_scyc", o_scyc, 3'b010);
    check("t1_sstb", o_sstb, 3'b010);
    check("t1_saddr", o_saddr[AW +: AW], A_S1);
    set_s(1, 1, 32'hA5A5_0001);
    #1;
    check("t1_mack", o_mack, 2'b01);
    sb_pop_check(o_mdata[0 +: DW]);
    check("t1_m1_data_zero", o_mdata[DW +: DW], 0);
    tick();
    set_s(1, 0, '0);
    idle_m(0);
    #1;
    check("t1_release_scyc", o_scyc, 3'b000);
    tick();

    // ---- contention on slave 0 ----
    drive_m(0, 1, 1, 1, A_S0, 32'h1111_1111);
    drive_m(1, 1, 1, 1, A_S0, 32'h2222_2222);
    sb_push("t2_first_m0", 32'h1111_1111);
    tick();
    check("t2_scyc", o_scyc, 3'b001);
    sb_pop_check(o_sdata[0 +: DW]);
    set_s(0, 1, '0);
    #1;
    check("t2_ack_m0", o_mack, 2'b01);
    tick();
    set_s(0, 0, '0);
    idle_m(0);
    sb_push("t2_then_m1", 32'h2222_2222);
    #1;
    check("t2_release_sstb", o_sstb, 3'b000);
    tick();
    check("t2_no_overlap", o_scyc, 3'b000);
    tick();
    check("t2_m1_scyc", o_scyc, 3'b001);
    sb_pop_check(o_sdata[0 +: DW]);
    set_s(0, 1, '0);
    #1;
    check("t2_ack_m1", o_mack, 2'b10);
    tick();
    set_s(0, 0, '0);
    idle_m(1);
    tick();
    drive_m(0, 1, 1, 1, A_S0, 32'h3333_3333);
    drive_m(1, 1, 1, 1, A_S0, 32'h4444_4444);
    sb_push("t2_tie_m0", 32'h3333_3333);
    tick();
    sb_pop_check(o_sdata[0 +: DW]);
    idle_m(0);
    idle_m(1);
    tick();
    tick();

    // ---- unmapped address from m1 ----
    drive_m(1, 1, 1, 0, A_UN, '0);
    #1;
    check("t3_no_err_same_cycle", o_merr, 2'b00);
    check("t3_no_sstb", o_sstb, 3'b000);
    tick();
    check("t3_err_pulse", o_merr, 2'b10);
    check("t3_no_scyc", o_scyc, 3'b000);
    tick();
    check("t3_err_one_cycle", o_merr, 2'b00);
    idle_m(1);
    tick();

    // ---- ack timeout on slave 2 ----
    drive_m(0, 1, 1, 0, A_S2, '0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("t4_merr_c%0d", i), o_merr[0], (i == 9));
    end
    check("t4_still_strobed", o_sstb, 3'b100);
    idle_m(0);
    tick();
    tick();
    drive_m(0, 1, 1, 0, A_S2, '0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("t4b_merr_c%0d", i), o_merr[0], (i == 9));
    end
    idle_m(0);
    tick();
    tick();

    // ---- parallel transactions, simultaneous acks ----
    drive_m(0, 1, 1, 0, A_S0, '0);
    drive_m(1, 1, 1, 0, A_S2, '0);
    sb_push("t5_rdata_m0", 32'hC0C0_0000);
    sb_push("t5_rdata_m1", 32'hC2C2_0002);
    tick();
    check("t5_sstb", o_sstb, 3'b101);
    set_s(0, 1, 32'hC0C0_0000);
    set_s(2, 1, 32'hC2C2_0002);
    #1;
    check("t5_mack", o_mack, 2'b11);
    sb_pop_check(o_mdata[0 +: DW]);
    sb_pop_check(o_mdata[DW +: DW]);
    tick();
    set_s(0, 0, '0);
    set_s(2, 0, '0);
    idle_m(0);
    idle_m(1);
    tick();
    tick();

    // ---- asynchronous reset mid-transaction ----
    drive_m(0, 1, 1, 1, A_S1, 32'h0000_00A0);
    tick();
    set_s(1, 1, '0);
    #1;
    check("t6_pre_mack", o_mack, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_scyc", o_scyc, 3'b000);
    check("t6_rst_mack", o_mack, 2'b00);
    check("t6_rst_merr", o_merr, 2'b00);
    set_s(1, 0, '0);
    drive_m(1, 1, 1, 1, A_S1, 32'h0000_00B1);
    sb_push("t6_rr_restart_m0", 32'h0000_00A0);
    #1 rst_n = 1'b1;
    tick();
    check("t6_scyc", o_scyc, 3'b010);
    sb_pop_check(o_sdata[DW +: DW]);
    idle_m(0);
    idle_m(1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
